// File: rtl/id_stage.sv
// Instruction decode: 32x32 register file, ISA decode into the ID/EX register, branch resolution. Optional ID_WB_BYPASS_EN.
// Latency: ID/EX outputs 1 cycle after the instruction is presented; branch_taken/branch_address combinational.
// Backpressure: stall loads a bubble into ID/EX and suppresses branch_taken; write-back proceeds regardless.
module id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic [31:0] pc_plus4,
    input  logic        stall,
    input  logic        wb_en,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_value,
    output logic        branch_taken,
    output logic [31:0] branch_address,
    output logic [3:0]  ex_alu_cmd,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_wb_en,
    output logic [4:0]  ex_dest,
    output logic [31:0] ex_val1,
    output logic [31:0] ex_val2,
    output logic [31:0] ex_st_val,
    output logic [31:0] ex_pc_plus4,
    output logic        ex_illegal
);

    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0010, ALU_AND = 4'b0100,
                           ALU_OR  = 4'b0101, ALU_NOR = 4'b0110, ALU_XOR = 4'b0111,
                           ALU_SLL = 4'b1000, ALU_SRL = 4'b1001, ALU_SRA = 4'b1010;

    logic [31:0] regs [32];

    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    assign op  = instruction[31:26];
    assign rd  = instruction[25:21];
    assign rs1 = instruction[20:16];
    assign rs2 = instruction[15:11];
    assign imm = {{16{instruction[15]}}, instruction[15:0]};

    logic [31:0] r_rd, r_rs1, r_rs2;

    always_comb begin
        r_rd  = (rd  == 5'd0) ? 32'h0 : regs[rd];
        r_rs1 = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
        r_rs2 = (rs2 == 5'd0) ? 32'h0 : regs[rs2];
`ifdef ID_WB_BYPASS_EN
        // Same-cycle write-back forwarding; index 0 stays hard-wired to zero.
        if (wb_en && wb_dest != 5'd0) begin
            if (wb_dest == rd)  r_rd  = wb_value;
            if (wb_dest == rs1) r_rs1 = wb_value;
            if (wb_dest == rs2) r_rs2 = wb_value;
        end
`endif
    end

    logic [3:0]  d_alu;
    logic        d_mr, d_mw, d_wb, d_ill, is_br, br_cond;
    logic [4:0]  d_dest;
    logic [31:0] d_v1, d_v2, d_st;

    always_comb begin
        d_alu = ALU_ADD; d_mr = 1'b0; d_mw = 1'b0; d_wb = 1'b0; d_ill = 1'b0;
        d_dest = 5'd0; d_v1 = 32'h0; d_v2 = 32'h0; d_st = 32'h0;
        is_br = 1'b0; br_cond = 1'b0;
        case (op)
            6'd0: ;
            6'd1, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12: begin
                d_wb = 1'b1; d_dest = rd; d_v1 = r_rs1; d_v2 = r_rs2;
                case (op)
                    6'd3:        d_alu = ALU_SUB;
                    6'd5:        d_alu = ALU_AND;
                    6'd6:        d_alu = ALU_OR;
                    6'd7:        d_alu = ALU_NOR;
                    6'd8:        d_alu = ALU_XOR;
                    6'd9, 6'd10: d_alu = ALU_SLL;
                    6'd11:       d_alu = ALU_SRA;
                    6'd12:       d_alu = ALU_SRL;
                    default:     d_alu = ALU_ADD;
                endcase
            end
            6'd32, 6'd33: begin
                d_wb = 1'b1; d_dest = rd; d_v1 = r_rs1; d_v2 = imm;
                d_alu = (op == 6'd33) ? ALU_SUB : ALU_ADD;
            end
            6'd36: begin
                d_mr = 1'b1; d_wb = 1'b1; d_dest = rd; d_v1 = r_rs1; d_v2 = imm;
            end
            // Store has no destination; rd names the data register.
            6'd37: begin
                d_mw = 1'b1; d_v1 = r_rs1; d_v2 = imm; d_st = r_rd;
            end
            6'd40: begin is_br = 1'b1; br_cond = (r_rd == 32'h0); end
            6'd41: begin is_br = 1'b1; br_cond = (r_rd != r_rs1); end
            6'd42: begin is_br = 1'b1; br_cond = 1'b1; end
            default: d_ill = 1'b1;
        endcase
    end

    assign branch_taken   = is_br & br_cond & ~stall;
    assign branch_address = is_br ? (pc_plus4 + {imm[29:0], 2'b00}) : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
        end else if (wb_en && wb_dest != 5'd0) begin
            regs[wb_dest] <= wb_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || stall) begin
            ex_alu_cmd   <= ALU_ADD;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_wb_en     <= 1'b0;
            ex_dest      <= 5'd0;
            ex_val1      <= 32'h0;
            ex_val2      <= 32'h0;
            ex_st_val    <= 32'h0;
            ex_illegal   <= 1'b0;
            ex_pc_plus4  <= rst ? RESET_PC : pc_plus4;
        end else begin
            ex_alu_cmd   <= d_alu;
            ex_mem_read  <= d_mr;
            ex_mem_write <= d_mw;
            ex_wb_en     <= d_wb;
            ex_dest      <= d_dest;
            ex_val1      <= d_v1;
            ex_val2      <= d_v2;
            ex_st_val    <= d_st;
            ex_illegal   <= d_ill;
            ex_pc_plus4  <= pc_plus4;
        end
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction decode stage of the 5-stage pipeline; sits directly downstream of the instruction fetch stage via the IF/ID register. It holds the 32×32 architectural register file and decodes the 18-opcode ISA into control and operands, captured in the ID/EX pipeline register. It also resolves branches, returning `branch_taken`/`branch_address` to instruction fetch. It accepts write-back from the WB stage.

## Interface
- `RESET_PC`, 32'h0 — value driven on `ex_pc_plus4` after reset.
- `clk` in 1 — pipeline clock; all state updates on posedge.
- `rst` in 1 — synchronous, active-high; one clock; reset is synchronous and active-high.
- `instruction` in 32 — from IF/ID register.
- `pc_plus4` in 32 — address of `instruction` + 4, from IF/ID register.
- `stall` in 1 — hazard unit; inject bubble instead of decoded instruction.
- `wb_en` in 1 — write-back enable.
- `wb_dest` in 5 — write-back register index.
- `wb_value` in 32 — write-back data.
- `branch_taken` out 1 — combinational; IF loads `branch_address` next edge and squashes IF/ID.
- `branch_address` out 32 — combinational branch/jump target.
- `ex_alu_cmd` out 4 — registered ALU command.
- `ex_mem_read`, `ex_mem_write`, `ex_wb_en` out 1 each — registered controls.
- `ex_dest` out 5 — registered destination index.
- `ex_val1`, `ex_val2`, `ex_st_val` out 32 each — registered operands.
- `ex_pc_plus4` out 32 — registered PC+4.
- `ex_illegal` out 1 — registered; undefined opcode decoded.

## Operation
- Fields: op=[31:26], rd=[25:21], rs1=[20:16], rs2=[15:11], imm=[15:0] sign-extended to 32.
- ALU commands: ADD 0000, SUB 0010, AND 0100, OR 0101, NOR 0110, XOR 0111, SLA/SLL 1000, SRL 1001, SRA 1010.
- Decode by op:
  - 0 NOP: all enables 0.
  - 1 ADD / 3 SUB / 5 AND / 6 OR / 7 NOR / 8 XOR / 9 SLA / 10 SLL / 11 SRA / 12 SRL: `wb_en`=1, dest=rd, val1=R[rs1], val2=R[rs2].
  - 32 ADDI / 33 SUBI: `wb_en`=1, val2=imm.
  - 36 LD: ADD, `mem_read`=1, `wb_en`=1, dest=rd, val1=R[rs1], val2=imm.
  - 37 ST: ADD, `mem_write`=1, `wb_en`=0, val1=R[rs1], val2=imm, st_val=R[rd].
  - 40 BEZ: taken if R[rd]==0.
  - 41 BNE: taken if R[rd]!=R[rs1].
  - 42 JMP: always taken.
  - Branches write nothing.
  - Any other op: decoded as NOP, `ex_illegal`=1.
- Branch target: `pc_plus4 + (imm<<2)`, modulo 2^32 (wraps).
- `branch_address` is 0 when no branch/jump is decoded.
- Register file:
  - R0 reads 0; writes to index 0 are ignored.
  - Write occurs on posedge when `wb_en`.
- `stall`=1:
  - ID/EX loads a bubble: all enables 0, `ex_alu_cmd`=0, `ex_illegal`=0; operand fields don't-care but driven 0.
  - `branch_taken` forced 0.
  - Register file write still performed.
- `rst`:
  - All 32 registers cleared to 0.
  - ID/EX cleared: all outputs 0 except `ex_pc_plus4`=`RESET_PC`.
  - Pending write-back in the same cycle is discarded.
  - `rst` overrides `stall` and `wb_en`.

## Timing
- Decode latency 1 cycle: instruction present in cycle N appears on `ex_*` after posedge ending cycle N.
- `branch_taken`/`branch_address` valid within cycle N (combinational from inputs and register file).
- Write-back in cycle N is visible to a read in cycle N+1 always; same-cycle visibility depends on configuration.
- Simultaneous branch and `stall`: stall wins; branch re-evaluated when the instruction is re-presented.

## Configuration
- `ID_WB_BYPASS_EN` defined:
  - A read of index k≠0 while `wb_en` && `wb_dest`==k returns `wb_value` in the same cycle, covering both operands and the branch compare.
- `ID_WB_BYPASS_EN` undefined:
  - Reads return stored value.
  - Hazard unit must stall one extra cycle.

## Test plan
- Reset, then NOP (32'h0) → all `ex_*` 0, `ex_pc_plus4`=`RESET_PC`, `branch_taken`=0.
- WB R4=5, then ADD r3 r4 r0 (32'h04640000) → `ex_alu_cmd`=0000, `ex_wb_en`=1, `ex_dest`=3, `ex_val1`=5, `ex_val2`=0.
- ADDI r5 r6 2 with R6=7; ST r9 r10 imm 8 with R9=1, R10=2 → ADDI: `ex_val2`=2. ST: `ex_mem_write`=1, `ex_val1`=2, `ex_val2`=8, `ex_st_val`=1, `ex_wb_en`=0.
- BEZ r11 imm=16'hFFFF, R11=0, `pc_plus4`=64 → `branch_taken`=1, `branch_address`=60. R11=3 → `branch_taken`=0. JMP with `stall`=1 → `branch_taken`=0 and bubble in ID/EX.
- Same cycle: `wb_en`=1, `wb_dest`=4, `wb_value`=9, decoding ADD with rs1=4 (R4 was 5) → `ex_val1`=9 with macro, 5 without. WB to R0 → R0 reads 0.
- Opcode 6'b111111 → `ex_illegal`=1, all enables 0. `rst` asserted mid-stream with `wb_en`=1 → next cycle all registers read 0.
